// File: rtl/tick_sched_pkg.sv
// Shared types and defaults for the tick scheduler: FSM states, default
// counter width and the reset-time half-period of each channel.
package tick_sched_pkg;

    localparam int DEFAULT_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    // Channel i powers up with half-period 2**i, saturated to the all-ones
    // value of a w-bit counter (w is at most 32).
    function automatic logic [31:0] reset_half(input int i, input int w);
        if (i >= w) begin
            return 32'hFFFF_FFFF >> (32 - w);
        end
        return 32'd1 << i;
    endfunction

endpackage

// File: rtl/tick_chan.sv
// One toggle channel: half-period down-counter, toggle flop and a registered
// edge pulse that coincides with the new waveform level.
module tick_chan
    import tick_sched_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         run,
    input  logic         freeze_high,
    input  logic         load,
    input  logic [W-1:0] half,
    output logic         wave,
    output logic         pulse
);

    logic [W-1:0] cnt;
    logic         hold;

    // While stopping, a channel that is already high is parked there.
    assign hold = freeze_high && wave;

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge values of its neighbours, whatever the block order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt   <= '0;
            wave  <= 1'b1;
            pulse <= 1'b0;
        end else if (load) begin
            cnt   <= half;
            wave  <= 1'b1;
            pulse <= 1'b0;
        end else if (run && !hold) begin
            if (cnt == W'(1)) begin
                wave  <= ~wave;
                pulse <= 1'b1;
                cnt   <= half;
            end else begin
                cnt   <= cnt - W'(1);
                pulse <= 1'b0;
            end
        end else begin
            pulse <= 1'b0;
        end
    end

endmodule

// File: rtl/tick_scheduler.sv
// N phase-aligned square-wave channels with programmable half-periods,
// started together and stopped cleanly at their idle (high) level.
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter  int N  = 2,
    parameter  int W  = DEFAULT_W,
    localparam int CW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_ch,
    input  logic [W-1:0]  cfg_half,
    input  logic          start,
    input  logic          stop,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  wave_out,
    output logic [N-1:0]  edge_out
);

    state_t       state;
    state_t       state_nx;
    logic         done_nx;
    logic         load;
    logic         wr_en;
    logic [W-1:0] wr_val;
    logic [W-1:0] half_q [N];

    assign cfg_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Out-of-range channels complete the handshake but write nothing.
    assign wr_en  = cfg_valid && cfg_ready && (int'(cfg_ch) < N);
    assign wr_val = (cfg_half == '0) ? W'(1) : cfg_half;

    // NOTE: every signal written here gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_nx = state;
        done_nx  = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = RUN;
                    load     = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_nx = STOPPING;
                end
            end
            STOPPING: begin
                if (&wave_out) begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= done_nx;
        end
    end

    // NOTE: the half-period file is reset because its power-up contents
    // (1, 2, 4, ...) are visible behaviour, not don't-care storage.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
                half_q[i] <= W'(reset_half(i, W));
            end else if (wr_en && int'(cfg_ch) == i) begin
                half_q[i] <= wr_val;
            end
        end
    end

    for (genvar g = 0; g < N; g++) begin : g_chan
        logic [W-1:0] ch_half;

        // A write coinciding with start is forwarded so the channel
        // launches with the freshly written value.
        assign ch_half = (wr_en && int'(cfg_ch) == g) ? wr_val : half_q[g];

        tick_chan #(.W(W)) u_chan (
            .clk         (clk),
            .rst_n       (rst_n),
            .run         (state != IDLE),
            .freeze_high (state == STOPPING),
            .load        (load),
            .half        (ch_half),
            .wave        (wave_out[g]),
            .pulse       (edge_out[g])
        );
    end

endmodule
